free_list: RTL and testbench

Circular FIFO of free physical register tags for the R10K rename stage. It sits directly upstream of the map table. Each cycle it supplies up to N new tags (T) for dispatching instructions, and it takes back T_old tags from retiring instructions. It also exposes its head pointer so branch checkpoints can capture it, and restores that pointer on mispredict so speculatively allocated tags are reclaimed in one cycle.

---
 rtl/free_list_if.sv | 56 +++++
 rtl/free_list.sv | 116 +++++++++++
 tb/tb_free_list.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
//------------------------------------------------------------------------------
// free_list_if
//   Bundle between the rename/retire logic and the free list.
//   master : rename/retire side (drives pop count, frees, restore)
//   slave  : free list (returns free tags, valid bits, count, head pointer)
//
//   rd_num       tags consumed by dispatch this cycle (0..N)
//   wr_en        per-lane retire free strobe
//   wr_reg       T_old tags being freed, one per lane
//   restore      mispredict rollback strobe
//   restore_head checkpointed head pointer to roll back to
//   free_reg     lane i = entry at head+i
//   free_valid   bit i set when more than i tags are held
//   free_count   number of free tags held
//   head_ptr     current head pointer, for branch checkpoints
// Revision: 1.0 initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef PHYS_REG_SIZE_R10K
`define PHYS_REG_SIZE_R10K 64
`endif

interface free_list_if #(
    parameter int N     = 2,
    parameter int DEPTH = `PHYS_REG_SIZE_R10K,
    parameter int ARCH  = 32
);
    localparam int FL_SIZE = DEPTH - ARCH;
    localparam int PW      = $clog2(FL_SIZE) + 1;
    localparam int TW      = $clog2(DEPTH);
    localparam int RW      = $clog2(N + 1);
    localparam int CW      = $clog2(FL_SIZE + 1);

    logic [RW-1:0]          rd_num;
    logic [N-1:0]           wr_en;
    logic [N-1:0][TW-1:0]   wr_reg;
    logic                   restore;
    logic [PW-1:0]          restore_head;
    logic [N-1:0][TW-1:0]   free_reg;
    logic [N-1:0]           free_valid;
    logic [CW-1:0]          free_count;
    logic [PW-1:0]          head_ptr;

    modport master (
        output rd_num, wr_en, wr_reg, restore, restore_head,
        input  free_reg, free_valid, free_count, head_ptr
    );

    modport slave (
        input  rd_num, wr_en, wr_reg, restore, restore_head,
        output free_reg, free_valid, free_count, head_ptr
    );
endinterface

`default_nettype wire

// File: rtl/free_list.sv
//------------------------------------------------------------------------------
// free_list
//   Circular FIFO of free physical register tags for the R10K rename stage.
//   Supplies up to N tags per cycle at the head, accepts up to N freed tags
//   per cycle at the tail, and rolls the head back to a checkpoint on a
//   mispredict so speculatively allocated tags are reclaimed in one cycle.
//
//   clock  system clock, rising-edge state updates
//   reset  asynchronous, active-low
//   bus    free_list_if.slave (see interface header for the signal list)
// Revision: 1.0 initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef PHYS_REG_SIZE_R10K
`define PHYS_REG_SIZE_R10K 64
`endif

module free_list #(
    parameter int N     = 2,
    parameter int DEPTH = `PHYS_REG_SIZE_R10K,
    parameter int ARCH  = 32
) (
    input  wire logic       clock,
    input  wire logic       reset,
    free_list_if.slave      bus
);
    // FL_SIZE must be a power of two so the index field wraps naturally.
    localparam int FL_SIZE = DEPTH - ARCH;
    localparam int IW      = $clog2(FL_SIZE);
    localparam int PW      = IW + 1;
    localparam int TW      = $clog2(DEPTH);
    localparam int RW      = $clog2(N + 1);
    localparam int CW      = $clog2(FL_SIZE + 1);

    logic [TW-1:0]  mem_q [FL_SIZE];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;

    logic [PW-1:0]  w_count;
    logic [RW-1:0]  w_push_cnt;
    logic [IW-1:0]  w_wr_idx [N];

    assign w_count = tail_q - head_q;

    // Compact enabled retire lanes: lane i lands at tail + (number of
    // enabled lanes below i).
    always_comb begin
        logic [PW-1:0] w_ptr;
        w_push_cnt = '0;
        w_ptr      = '0;
        for (int i = 0; i < N; i++) begin
            w_ptr       = tail_q + PW'(w_push_cnt);
            w_wr_idx[i] = w_ptr[IW-1:0];
            if (bus.wr_en[i]) begin
                w_push_cnt = w_push_cnt + RW'(1);
            end
        end
    end

    // A restore overrides the pop; entries between the checkpoint and the
    // current head were never overwritten, so they simply become free again.
    always_comb begin
        head_d = bus.restore ? bus.restore_head : head_q + PW'(bus.rd_num);
        tail_d = tail_q + PW'(w_push_cnt);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= PW'(FL_SIZE);
            for (int i = 0; i < FL_SIZE; i++) begin
                mem_q[i] <= TW'(ARCH + i);
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < N; i++) begin
                if (bus.wr_en[i]) begin
                    mem_q[w_wr_idx[i]] <= bus.wr_reg[i];
                end
            end
        end
    end

    // Read side is purely combinational from storage and head: a tag freed
    // this cycle is not visible until the next one.
    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [PW-1:0] w_rd_ptr;
        assign w_rd_ptr           = head_q + PW'(g);
        assign bus.free_reg[g]    = mem_q[w_rd_ptr[IW-1:0]];
        assign bus.free_valid[g]  = (w_count > PW'(g));
    end

    assign bus.free_count = CW'(w_count);
    assign bus.head_ptr   = head_q;

`ifndef SYNTHESIS
    logic [PW-1:0] w_after_pop;
    assign w_after_pop = tail_q - head_d;

    always @(posedge clock) begin
        if (reset) begin
            if (!bus.restore) begin
                assert (PW'(bus.rd_num) <= w_count)
                    else $error("free_list: pop of %0d with only %0d held", bus.rd_num, w_count);
            end
            assert (int'(w_after_pop) + int'(w_push_cnt) <= FL_SIZE)
                else $error("free_list: push overflows capacity");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none

module tb_free_list;
    localparam int N     = 2;
    localparam int DEPTH = 64;
    localparam int ARCH  = 32;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;
    logic [5:0] saved_head;

    free_list_if #(.N(N), .DEPTH(DEPTH), .ARCH(ARCH)) fl_if ();

    free_list #(.N(N), .DEPTH(DEPTH), .ARCH(ARCH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (fl_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            else begin
                n_bad++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            end
    endtask

    task automatic clear_inputs();
        fl_if.rd_num       = '0;
        fl_if.wr_en        = '0;
        fl_if.wr_reg[0]    = '0;
        fl_if.wr_reg[1]    = '0;
        fl_if.restore      = 1'b0;
        fl_if.restore_head = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Reset state
        check("rst_reg0",  fl_if.free_reg[0], 32);
        check("rst_reg1",  fl_if.free_reg[1], 33);
        check("rst_valid", fl_if.free_valid, 2'b11);
        check("rst_count", fl_if.free_count, 32);
        check("rst_head",  fl_if.head_ptr, 0);

        // Drain two per cycle
        fl_if.rd_num = 2'd2;
        for (int k = 0; k < 16; k++) begin
            step();
            check("drain_count", fl_if.free_count, 30 - 2 * k);
            if (k == 0) check("drain_reg0", fl_if.free_reg[0], 34);
        end
        fl_if.rd_num = '0;
        check("empty_valid", fl_if.free_valid, 2'b00);
        check("empty_head",  fl_if.head_ptr, 32);

        // Push two from empty
        fl_if.wr_en     = 2'b11;
        fl_if.wr_reg[0] = 6'd7;
        fl_if.wr_reg[1] = 6'd5;
        step();
        clear_inputs();
        check("push_reg0",  fl_if.free_reg[0], 7);
        check("push_reg1",  fl_if.free_reg[1], 5);
        check("push_count", fl_if.free_count, 2);
        check("push_valid", fl_if.free_valid, 2'b11);

        // count=1 with tag 7 at head, then simultaneous pop and push
        do_reset();
        fl_if.rd_num = 2'd2;
        repeat (16) step();
        fl_if.rd_num    = '0;
        fl_if.wr_en     = 2'b01;
        fl_if.wr_reg[0] = 6'd7;
        step();
        clear_inputs();
        check("one_count", fl_if.free_count, 1);
        check("one_reg0",  fl_if.free_reg[0], 7);
        check("one_valid", fl_if.free_valid, 2'b01);
        fl_if.rd_num    = 2'd1;
        fl_if.wr_en     = 2'b10;
        fl_if.wr_reg[1] = 6'd9;
        #1;
        check("sim_popped", fl_if.free_reg[0], 7);
        step();
        clear_inputs();
        check("sim_count", fl_if.free_count, 1);
        check("sim_reg0",  fl_if.free_reg[0], 9);
        check("sim_head",  fl_if.head_ptr, 33);

        // Restore after speculative pops
        do_reset();
        saved_head = fl_if.head_ptr;
        check("ckpt_head", saved_head, 0);
        fl_if.rd_num = 2'd2;
        repeat (3) step();
        fl_if.rd_num = '0;
        check("spec_count", fl_if.free_count, 26);
        check("spec_reg0",  fl_if.free_reg[0], 38);
        fl_if.restore      = 1'b1;
        fl_if.restore_head = saved_head;
        fl_if.rd_num       = 2'd2;
        step();
        clear_inputs();
        check("rest_count", fl_if.free_count, 32);
        check("rest_reg0",  fl_if.free_reg[0], 32);
        check("rest_head",  fl_if.head_ptr, 0);

        // Steady-state recycle with pointer wrap
        fl_if.rd_num = 2'd2;
        fl_if.wr_en  = 2'b11;
        for (int k = 0; k < 40; k++) begin
            fl_if.wr_reg[0] = fl_if.free_reg[0];
            fl_if.wr_reg[1] = fl_if.free_reg[1];
            step();
            check("wrap_count", fl_if.free_count, 32);
        end
        clear_inputs();
        check("wrap_head", fl_if.head_ptr, 16);
        check("wrap_reg0", fl_if.free_reg[0], 48);
        check("wrap_reg1", fl_if.free_reg[1], 49);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b0;
        #1;
        check("arst_head",  fl_if.head_ptr, 0);
        check("arst_reg0",  fl_if.free_reg[0], 32);
        check("arst_reg1",  fl_if.free_reg[1], 33);
        check("arst_count", fl_if.free_count, 32);
        check("arst_valid", fl_if.free_valid, 2'b11);
        @(negedge clock);
        reset = 1'b1;
        step();
        check("post_head", fl_if.head_ptr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
